// File: rtl/std_fifo_flex.sv
// std_fifo_flex -- general-purpose synchronous FIFO between streaming stages.
//
// Depth may be any value >= 2. Pointers wrap explicitly at DEPTH-1, and the
// occupancy counter is held in a register. Every status flag is decoded from
// that counter.
//
// Read modes:
//   FWFT = 0 : standard registered read; q loads the head word on an accepted
//              pop and shows it on the following cycle.
//   FWFT = 1 : first-word-fall-through; q shows ram[rd_ptr] combinationally
//              and a pop acknowledges the word currently on q.
//
// Optional feature (macro STD_FIFO_FLEX_ERR_EN):
//   When defined, overflow and underflow are sticky error flags. They set on a
//   rejected push or a rejected pop, and clear on rst or clr.
//   When undefined, both outputs are tied to 0.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active low
//   clr          in   synchronous flush; wins over push/pop in the same cycle
//   push         in   write request
//   pop          in   read request
//   d            in   write data [WIDTH]
//   q            out  read data [WIDTH]
//   full         out  count == DEPTH
//   empty        out  count == 0
//   count        out  occupancy 0..DEPTH [CNT_W]
//   almost_empty out  count <= ALMOST_EMPTY_COUNT
//   almost_full  out  count >= DEPTH - ALMOST_FULL_COUNT
//   overflow     out  sticky: a push was rejected
//   underflow    out  sticky: a pop was rejected
module std_fifo_flex #(
  parameter  int WIDTH              = 8,
  parameter  int DEPTH              = 6,
  parameter  int FWFT               = 0,
  parameter  int ALMOST_EMPTY_COUNT = 1,
  parameter  int ALMOST_FULL_COUNT  = 1,
  // The RAM index must reach DEPTH-1 for every DEPTH >= 2.
  localparam int ADDR_W             = $clog2(DEPTH),
  localparam int CNT_W              = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             almost_empty,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0]  ram [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // Wrap by explicit compare: DEPTH need not be a power of two.
  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] ptr);
    return (ptr == ADDR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_empty = (count <= CNT_W'(ALMOST_EMPTY_COUNT));
  assign almost_full  = (count >= CNT_W'(DEPTH - ALMOST_FULL_COUNT));

  // A push into a full FIFO is accepted when a pop frees the slot in the same
  // cycle. A pop from an empty FIFO is never accepted, even alongside a push.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset. When the FIFO is full, push and pop share one
  // index; the read below samples the old word before this write lands.
  always_ff @(posedge clk) begin
    if (push_ok && !clr) ram[wr_ptr] <= d;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign q = ram[rd_ptr];
    end else begin : g_std
      logic [WIDTH-1:0] q_reg;
      // The flush leaves the last read word on q.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) q_reg <= '0;
        else if (pop_ok && !clr) q_reg <= ram[rd_ptr];
      end
      assign q = q_reg;
    end
  endgenerate

`ifdef STD_FIFO_FLEX_ERR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && !push_ok) overflow  <= 1'b1;
      if (pop && !pop_ok)   underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_std_fifo_flex.sv
// Testbench for std_fifo_flex. Two instances share one stimulus: a standard
// read-mode FIFO (dut0) and an FWFT FIFO (dut1). Both are checked every cycle
// against a queue-based model of the FIFO contents.
module tb_std_fifo_flex;
  localparam int W   = 8;
  localparam int DP  = 6;
  localparam int AE  = 1;
  localparam int AF  = 1;
  localparam int CW  = $clog2(DP) + 1;
`ifdef STD_FIFO_FLEX_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, clr, push, pop;
  logic [W-1:0]  d;
  logic [W-1:0]  q0, q1;
  logic          full0, empty0, ae0, af0, ovf0, unf0;
  logic          full1, empty1, ae1, af1, ovf1, unf1;
  logic [CW-1:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state: queued words, the standard-mode q register, and the sticky
  // error flags.
  logic [W-1:0] mq[$];
  logic [W-1:0] mq0;
  bit           movf, munf;

  always #5 clk = ~clk;

  std_fifo_flex #(.WIDTH(W), .DEPTH(DP), .FWFT(0), .ALMOST_EMPTY_COUNT(AE),
                  .ALMOST_FULL_COUNT(AF)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop), .d(d), .q(q0),
    .full(full0), .empty(empty0), .count(cnt0), .almost_empty(ae0),
    .almost_full(af0), .overflow(ovf0), .underflow(unf0));

  std_fifo_flex #(.WIDTH(W), .DEPTH(DP), .FWFT(1), .ALMOST_EMPTY_COUNT(AE),
                  .ALMOST_FULL_COUNT(AF)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop), .d(d), .q(q1),
    .full(full1), .empty(empty1), .count(cnt1), .almost_empty(ae1),
    .almost_full(af1), .overflow(ovf1), .underflow(unf1));

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: checks both instances against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("count0", 32'(cnt0), 32'(mq.size()));
      cmp("full0",  32'(full0), 32'(mq.size() == DP));
      cmp("empty0", 32'(empty0), 32'(mq.size() == 0));
      cmp("aempty0", 32'(ae0), 32'(mq.size() <= AE));
      cmp("afull0", 32'(af0), 32'(mq.size() >= DP - AF));
      cmp("ovf0",   32'(ovf0), 32'(movf));
      cmp("unf0",   32'(unf0), 32'(munf));
      cmp("q0",     32'(q0), 32'(mq0));
      cmp("count1", 32'(cnt1), 32'(mq.size()));
      cmp("full1",  32'(full1), 32'(mq.size() == DP));
      cmp("empty1", 32'(empty1), 32'(mq.size() == 0));
      cmp("aempty1", 32'(ae1), 32'(mq.size() <= AE));
      cmp("afull1", 32'(af1), 32'(mq.size() >= DP - AF));
      cmp("ovf1",   32'(ovf1), 32'(movf));
      cmp("unf1",   32'(unf1), 32'(munf));
      if (mq.size() > 0) cmp("q1_head", 32'(q1), 32'(mq[0]));
    end
  end

  // One clock cycle of stimulus. Acceptance is decided from the model state
  // before the edge, and the model is advanced at the edge. Pop is applied
  // before push, so a full FIFO with push and pop together returns the old head.
  task automatic step(input bit p, input bit o, input logic [W-1:0] dd, input bit c);
    bit pok, ook;
    push = p; pop = o; d = dd; clr = c;
    pok = p && ((mq.size() < DP) || o);
    ook = o && (mq.size() > 0);
    @(posedge clk);
    if (c) begin
      mq.delete();
      movf = 1'b0;
      munf = 1'b0;
    end else begin
      if (ook) mq0 = mq.pop_front();
      if (pok) mq.push_back(dd);
      if (ERR_EN && p && !pok) movf = 1'b1;
      if (ERR_EN && o && !ook) munf = 1'b1;
    end
    #1;
    push = 1'b0; pop = 1'b0; clr = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    mq0  = '0;
    movf = 1'b0;
    munf = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] val, exp;
    rst = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; d = '0;
    model_reset();
    #1 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    cmp("rst_count", 32'(cnt0), 32'd0);
    cmp("rst_empty", 32'(empty0), 32'd1);
    cmp("rst_full",  32'(full0), 32'd0);
    cmp("rst_ae",    32'(ae0), 32'd1);
    cmp("rst_af",    32'(af0), 32'd0);
    cmp("rst_q",     32'(q0), 32'd0);
    #1 rst = 1'b1;

    // Fill 0x11..0x16, watching almost_full and full come up.
    for (int i = 0; i < 4; i++) step(1, 0, 8'(8'h11 + i), 0);
    cmp("af_at4", 32'(af0), 32'd0);
    step(1, 0, 8'h15, 0);
    cmp("af_at5", 32'(af0), 32'd1);
    step(1, 0, 8'h16, 0);
    cmp("fill_full", 32'(full0), 32'd1);
    cmp("fill_count", 32'(cnt0), 32'd6);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 8'h00, 0);
      cmp("pop_seq_q", 32'(q0), 32'(8'h11 + i));
    end
    cmp("drain_empty", 32'(empty0), 32'd1);

    // Pointer wrap: push 4 / pop 4 repeatedly, order must hold across the wrap.
    val = 8'h00; exp = 8'h00;
    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k < 4; k++) begin step(1, 0, val, 0); val++; end
      cmp("wrap_count", 32'(cnt0), 32'd4);
      for (int k = 0; k < 4; k++) begin
        step(0, 1, 8'h00, 0);
        cmp("wrap_q", 32'(q0), 32'(exp));
        exp++;
      end
    end

    // Full with push and pop together: the old head leaves and 0xB0 enters.
    for (int i = 0; i < 6; i++) step(1, 0, 8'(8'hA0 + i), 0);
    cmp("full_fwft_old_head", 32'(q1), 32'h0A0);
    step(1, 1, 8'hB0, 0);
    cmp("fullpp_count", 32'(cnt0), 32'd6);
    cmp("fullpp_q", 32'(q0), 32'h0A0);
    cmp("fullpp_ovf", 32'(ovf0), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 8'h00, 0);
      cmp("fullpp_seq", 32'(q0), (i < 5) ? 32'(8'hA1 + i) : 32'h0B0);
    end

    // Empty with push and pop together: only the push is taken.
    step(1, 1, 8'h3C, 0);
    cmp("emptypp_count", 32'(cnt0), 32'd1);
    cmp("emptypp_unf", 32'(unf0), 32'(ERR_EN));
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h40 + i), 0);
    step(1, 0, 8'hFF, 0);
    cmp("ovf_count", 32'(cnt0), 32'd6);
    cmp("ovf_flag", 32'(ovf0), 32'(ERR_EN));
    step(0, 0, 8'h00, 1);
    cmp("clr_count", 32'(cnt0), 32'd0);
    cmp("clr_ovf", 32'(ovf0), 32'd0);
    cmp("clr_unf", 32'(unf0), 32'd0);

    // FWFT behaviour.
    step(1, 0, 8'h5A, 0);
    cmp("fwft_q_5a", 32'(q1), 32'h05A);
    cmp("fwft_nonempty", 32'(empty1), 32'd0);
    step(0, 1, 8'h00, 0);
    cmp("fwft_empty", 32'(empty1), 32'd1);
    step(1, 0, 8'h01, 0);
    step(1, 0, 8'h02, 0);
    cmp("fwft_q_01", 32'(q1), 32'h001);
    step(0, 1, 8'h00, 0);
    cmp("fwft_q_02", 32'(q1), 32'h002);
    step(0, 1, 8'h00, 0);

    // Asynchronous reset between edges.
    for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h21 + i), 0);
    #2 rst = 1'b0;
    model_reset();
    #1;
    cmp("arst_count", 32'(cnt0), 32'd0);
    cmp("arst_empty", 32'(empty0), 32'd1);
    cmp("arst_q", 32'(q0), 32'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    step(1, 0, 8'h77, 0);
    cmp("post_rst_count", 32'(cnt0), 32'd1);
    cmp("post_rst_fwft_q", 32'(q1), 32'h077);
    step(0, 1, 8'h00, 0);
    cmp("post_rst_q", 32'(q0), 32'h077);

    // Randomized traffic in push-heavy, pop-heavy and balanced phases.
    for (int ph = 0; ph < 3; ph++) begin
      for (int n = 0; n < 200; n++) begin
        int pp, op;
        pp = (ph == 0) ? 80 : (ph == 1) ? 30 : 55;
        op = (ph == 0) ? 30 : (ph == 1) ? 80 : 55;
        step($urandom_range(0, 99) < pp, $urandom_range(0, 99) < op,
             8'($urandom_range(0, 255)), $urandom_range(0, 99) < 2);
      end
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
